// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment display blocks.
package seg_pkg;

   localparam int NUM_DIGITS = 8;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // One display buffer entry: enable, decimal point, hex nibble.
   typedef struct packed {
      logic       en;
      logic       dp;
      logic [3:0] hex;
   } digit_t;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_t;

   // Counter width able to hold 0..n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Digit write port and commit handshake between the application and the scan controller.
interface seg_scan_ctrl_if;
   import seg_pkg::*;

   logic                          wr_valid;
   logic                          wr_ready;
   logic [$clog2(NUM_DIGITS)-1:0] wr_addr;
   logic [3:0]                    wr_hex;
   logic                          wr_dp;
   logic                          wr_en;
   logic                          commit_valid;
   logic                          commit_ready;

   // Application side: issues writes and commits.
   modport master (
      output wr_valid, wr_addr, wr_hex, wr_dp, wr_en, commit_valid,
      input  wr_ready, commit_ready
   );

   // Controller side: accepts writes and commits.
   modport slave (
      input  wr_valid, wr_addr, wr_hex, wr_dp, wr_en, commit_valid,
      output wr_ready, commit_ready
   );

endinterface

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module hex7seg
   import seg_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg_n
);

   // Standard hex glyphs; lower-case b and d keep them distinct from 8 and 0.
   always_comb begin
      seg_n = SEG_BLANK;
      case (hex)
         4'h0: seg_n = 7'h40;
         4'h1: seg_n = 7'h79;
         4'h2: seg_n = 7'h24;
         4'h3: seg_n = 7'h30;
         4'h4: seg_n = 7'h19;
         4'h5: seg_n = 7'h12;
         4'h6: seg_n = 7'h02;
         4'h7: seg_n = 7'h78;
         4'h8: seg_n = 7'h00;
         4'h9: seg_n = 7'h10;
         4'hA: seg_n = 7'h08;
         4'hB: seg_n = 7'h03;
         4'hC: seg_n = 7'h46;
         4'hD: seg_n = 7'h21;
         4'hE: seg_n = 7'h06;
         4'hF: seg_n = 7'h0E;
         default: seg_n = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit multiplexed display scanner with double-buffered digit store,
// blanking dead time between digits and per-digit blink.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DWELL_CYC = 50_000,
   parameter int BLANK_CYC = 500,
   parameter int BLINK_CYC = 25_000_000
)(
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   seg_scan_ctrl_if.slave        bus,
   input  logic [NUM_DIGITS-1:0] blink_mask,
   output logic                  frame_done,
   output logic [NUM_DIGITS-1:0] sel_n,
   output logic [6:0]            seg_n,
   output logic                  dp_n
);

   // One counter serves both phases, so size it for the longer one.
   localparam int SCAN_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
   localparam int SCAN_W   = cnt_w(SCAN_MAX);
   localparam int BLINK_W  = cnt_w(BLINK_CYC);
   localparam int IDX_W    = $clog2(NUM_DIGITS);

   localparam logic [SCAN_W-1:0]  DWELL_LAST = SCAN_W'(DWELL_CYC - 1);
   localparam logic [SCAN_W-1:0]  BLANK_LAST = SCAN_W'(BLANK_CYC - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   digit_t [NUM_DIGITS-1:0] shadow;
   digit_t [NUM_DIGITS-1:0] active;
   logic                    pending;

   scan_state_t             state;
   logic [IDX_W-1:0]        idx;
   logic [SCAN_W-1:0]       cnt;

   logic [BLINK_W-1:0]      blink_cnt;
   logic                    blink_phase;

   logic                    wr_acc;
   logic                    cm_acc;
   logic                    last_blank;
   logic                    last_show;
   logic                    frame_end;
   digit_t                  cur;
   logic                    dig_blank;
   logic [6:0]              dec_seg;

   // Both ports stall while a commit waits for the frame boundary so the
   // shadow copy cannot change between acceptance and transfer.
   assign bus.wr_ready     = !pending;
   assign bus.commit_ready = !pending;
   assign wr_acc           = bus.wr_valid && !pending;
   assign cm_acc           = bus.commit_valid && !pending;

   assign last_blank = (state == BLANK) && (cnt == BLANK_LAST);
   assign last_show  = (state == SHOW) && (cnt == DWELL_LAST);
   assign frame_end  = last_show && (idx == IDX_LAST);

   // Only the active buffer ever reaches the pins.
   assign cur       = active[idx];
   assign dig_blank = !cur.en || (blink_mask[idx] && blink_phase);

   hex7seg u_dec (
      .hex   (cur.hex),
      .seg_n (dec_seg)
   );

   // Shadow writes, commit tracking and shadow-to-active transfer at frame end.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         shadow  <= '0;
         active  <= '0;
         pending <= 1'b0;
      end else begin
         if (wr_acc)
            shadow[bus.wr_addr] <= '{en: bus.wr_en, dp: bus.wr_dp, hex: bus.wr_hex};
         if (frame_end && pending) begin
            active  <= shadow;
            pending <= 1'b0;
         end else if (cm_acc) begin
            pending <= 1'b1;
         end
      end
   end

   // Free-running blink timebase, unrelated to the scan position.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= !blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + 1'b1;
      end
   end

   // Scan FSM with registered pins; sel_n and seg_n move on the same edge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= BLANK;
         idx        <= '0;
         cnt        <= '0;
         sel_n      <= '1;
         seg_n      <= SEG_BLANK;
         dp_n       <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_end && pending;
         case (state)
            BLANK: begin
               sel_n <= '1;
               seg_n <= SEG_BLANK;
               dp_n  <= 1'b1;
               if (last_blank) begin
                  state <= SHOW;
                  cnt   <= '0;
               end else begin
                  cnt   <= cnt + 1'b1;
               end
            end
            SHOW: begin
               // Blanked digits still get their select so scan timing stays uniform.
               sel_n      <= '1;
               sel_n[idx] <= 1'b0;
               seg_n      <= dig_blank ? SEG_BLANK : dec_seg;
               dp_n       <= dig_blank ? 1'b1 : !cur.dp;
               if (last_show) begin
                  state <= BLANK;
                  cnt   <= '0;
                  idx   <= idx + 1'b1;
               end else begin
                  cnt   <= cnt + 1'b1;
               end
            end
            default: begin
               state <= BLANK;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic, every cycle
// compared against a frame-position reference model.
module tb_seg_scan_ctrl;

   localparam int DWELL = 8;
   localparam int BLNK  = 2;
   localparam int BLINK = 64;
   localparam int SLOT  = DWELL + BLNK;
   localparam int FRAME = 8 * SLOT;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic [7:0] blink_mask;
   logic       frame_done;
   logic [7:0] sel_n;
   logic [6:0] seg_n;
   logic       dp_n;

   seg_scan_ctrl_if bus ();

   seg_scan_ctrl #(
      .DWELL_CYC (DWELL),
      .BLANK_CYC (BLNK),
      .BLINK_CYC (BLINK)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .bus        (bus),
      .blink_mask (blink_mask),
      .frame_done (frame_done),
      .sel_n      (sel_n),
      .seg_n      (seg_n),
      .dp_n       (dp_n)
   );

   always #5 sys_clk = ~sys_clk;

   // Glyph table {g,f,e,d,c,b,a}, active low.
   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int tests = 0;
   int fails = 0;

   // Reference model: display position derived from cycle count since reset.
   int         t;
   logic [5:0] m_shadow [8];
   logic [5:0] m_active [8];
   bit         m_pend;
   logic [7:0] e_sel;
   logic [6:0] e_seg;
   logic       e_dp;
   logic       e_fd;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, t);
      end
   endtask

   function automatic void model_reset();
      t = 0;
      m_pend = 0;
      for (int i = 0; i < 8; i++) begin
         m_shadow[i] = '0;
         m_active[i] = '0;
      end
      e_sel = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
   endfunction

   // Advance one clock: pins for the next cycle reflect this cycle's position.
   function automatic void model_step();
      int pos, slot, dg;
      bit blank;
      logic [7:0] one;
      one  = 8'd1;
      pos  = t % FRAME;
      slot = pos % SLOT;
      dg   = pos / SLOT;
      if (slot < BLNK) begin
         e_sel = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
         e_sel = ~(one << dg);
         blank = !m_active[dg][5] || (blink_mask[dg] && ((t / BLINK) % 2 == 1));
         e_seg = blank ? 7'h7F : seg_tab[m_active[dg][3:0]];
         e_dp  = blank ? 1'b1 : !m_active[dg][4];
      end
      e_fd = (pos == FRAME - 1) && m_pend;
      if (pos == FRAME - 1 && m_pend) begin
         for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
         m_pend = 0;
      end else if (!m_pend) begin
         if (bus.wr_valid) m_shadow[bus.wr_addr] = {bus.wr_en, bus.wr_dp, bus.wr_hex};
         if (bus.commit_valid) m_pend = 1;
      end
      t++;
   endfunction

   task automatic check_pins(input string ph);
      chk({ph, ".sel_n"}, sel_n, e_sel);
      chk({ph, ".seg_n"}, {1'b0, seg_n}, {1'b0, e_seg});
      chk({ph, ".dp_n"}, {7'b0, dp_n}, {7'b0, e_dp});
      chk({ph, ".frame_done"}, {7'b0, frame_done}, {7'b0, e_fd});
      chk({ph, ".wr_ready"}, {7'b0, bus.wr_ready}, {7'b0, !m_pend});
      chk({ph, ".commit_ready"}, {7'b0, bus.commit_ready}, {7'b0, !m_pend});
   endtask

   task automatic tick(input string ph);
      @(posedge sys_clk);
      model_step();
      @(negedge sys_clk);
      check_pins(ph);
   endtask

   task automatic run(input string ph, input int n);
      repeat (n) tick(ph);
   endtask

   task automatic wr(input string ph, input logic [2:0] a, input logic [3:0] h,
                     input logic d, input logic e, input logic cm);
      bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_hex = h; bus.wr_dp = d; bus.wr_en = e;
      bus.commit_valid = cm;
      tick(ph);
      bus.wr_valid = 1'b0; bus.commit_valid = 1'b0;
   endtask

   task automatic commit(input string ph);
      bus.commit_valid = 1'b1;
      tick(ph);
      bus.commit_valid = 1'b0;
   endtask

   task automatic reset_checks(input string ph);
      chk({ph, ".rst_sel"}, sel_n, 8'hFF);
      chk({ph, ".rst_seg"}, {1'b0, seg_n}, 8'h7F);
      chk({ph, ".rst_dp"}, {7'b0, dp_n}, 8'h01);
      chk({ph, ".rst_fd"}, {7'b0, frame_done}, 8'h00);
      chk({ph, ".rst_ready"}, {7'b0, bus.wr_ready}, 8'h01);
   endtask

   initial begin
      int fd_cnt;
      sys_rst_n = 1'b0;
      blink_mask = 8'h00;
      bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_hex = '0; bus.wr_dp = 1'b0;
      bus.wr_en = 1'b0; bus.commit_valid = 1'b0;
      model_reset();
      repeat (3) @(negedge sys_clk);
      reset_checks("init");
      sys_rst_n = 1'b1;

      // 1: idle scan, all digits blank
      run("idle", FRAME + 12);

      // 2: two digits then commit; exactly one frame_done pulse
      wr("wr2", 3'd0, 4'h8, 1'b1, 1'b1, 1'b0);
      wr("wr2", 3'd3, 4'h2, 1'b0, 1'b1, 1'b0);
      commit("cm2");
      chk("cm2.ready_low", {7'b0, bus.wr_ready}, 8'h00);
      fd_cnt = 0;
      repeat (2 * FRAME) begin
         tick("frm2");
         if (frame_done) fd_cnt++;
      end
      chk("frm2.fd_pulses", fd_cnt[7:0], 8'd1);

      // 3: uncommitted write must not show for three frames
      wr("wr3", 3'd1, 4'h1, 1'b0, 1'b1, 1'b0);
      run("hold3", 3 * FRAME);
      commit("cm3");
      run("frm3", 2 * FRAME);

      // 4: write and commit in the same cycle
      wr("wr4", 3'd5, 4'hA, 1'b0, 1'b1, 1'b1);
      chk("wr4.pending", {7'b0, bus.commit_ready}, 8'h00);
      run("frm4", 2 * FRAME);

      // 5: blink digit 0
      blink_mask = 8'h01;
      run("blink5", 3 * FRAME);
      blink_mask = 8'h00;

      // random traffic
      for (int i = 0; i < 600; i++) begin
         bus.wr_valid     = ($urandom_range(3) == 0);
         bus.wr_addr      = 3'($urandom_range(7));
         bus.wr_hex       = 4'($urandom_range(15));
         bus.wr_dp        = 1'($urandom_range(1));
         bus.wr_en        = ($urandom_range(4) != 0);
         bus.commit_valid = ($urandom_range(15) == 0);
         if ($urandom_range(63) == 0) blink_mask = 8'($urandom_range(255));
         tick("rand");
      end
      bus.wr_valid = 1'b0; bus.commit_valid = 1'b0;

      // 6: reset mid-SHOW with a commit pending
      while (t % FRAME != 20) tick("align6");
      wr("wr6", 3'd2, 4'hF, 1'b1, 1'b1, 1'b1);
      while (t % FRAME != 45) tick("pend6");
      chk("pre6.pending", {7'b0, bus.wr_ready}, 8'h00);
      #2 sys_rst_n = 1'b0;
      #1 reset_checks("mid6");
      model_reset();
      @(negedge sys_clk);
      reset_checks("hold6");
      sys_rst_n = 1'b1;
      run("post6", FRAME + 12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
